// File: rtl/sar_pkg.sv
// sar_pkg: shared types for the SAR conversion controller.
// SAR_SETTLE_EN adds a settle state ahead of every compare.
package sar_pkg;

  localparam int SAR_DEF_RES = 8;

`ifdef SAR_SETTLE_EN
  typedef enum logic [2:0] {
    S_IDLE,
    S_SAMPLE,
    S_SETTLE,
    S_CONVERT,
    S_DONE
  } sar_state_t;
`else
  typedef enum logic [1:0] {
    S_IDLE,
    S_SAMPLE,
    S_CONVERT,
    S_DONE
  } sar_state_t;
`endif

endpackage

// File: rtl/sar_controller.sv
// sar_controller: successive-approximation sequencer.
// Macro SAR_SETTLE_EN inserts one settle cycle before each compare.
module sar_controller
  import sar_pkg::*;
#(
  parameter int RESOLUTION    = SAR_DEF_RES,
  parameter int IDX_WIDTH     = $clog2(RESOLUTION),
  parameter int SAMPLE_CYCLES = 2
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  comp,
  output logic                  busy,
  output logic                  sample,
  output logic                  dec_enable,
  output logic [IDX_WIDTH-1:0]  bit_idx,
  output logic [RESOLUTION-1:0] trial,
  output logic [RESOLUTION-1:0] result,
  output logic                  done
);

  sar_state_t state;
  logic [3:0] cnt;

  // Conversion sequencer; every output is a register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      cnt        <= '0;
      busy       <= 1'b0;
      sample     <= 1'b0;
      dec_enable <= 1'b0;
      bit_idx    <= '0;
      trial      <= '0;
      result     <= '0;
      done       <= 1'b0;
    end else begin
      unique case (state)
        S_IDLE: begin
          done <= 1'b0;
          if (start) begin
            state  <= S_SAMPLE;
            cnt    <= 4'(SAMPLE_CYCLES - 1);
            busy   <= 1'b1;
            sample <= 1'b1;
          end
        end
        S_SAMPLE: begin
          if (cnt == 4'd0) begin
            sample  <= 1'b0;
            bit_idx <= IDX_WIDTH'(RESOLUTION - 1);
            trial   <= RESOLUTION'(1) << (RESOLUTION - 1);
`ifdef SAR_SETTLE_EN
            state   <= S_SETTLE;
`else
            state      <= S_CONVERT;
            dec_enable <= 1'b1;
`endif
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
`ifdef SAR_SETTLE_EN
        S_SETTLE: begin
          state      <= S_CONVERT;
          dec_enable <= 1'b1;
        end
`endif
        S_CONVERT: begin
          if (bit_idx != '0) begin
            trial[bit_idx]                  <= comp;
            trial[bit_idx - IDX_WIDTH'(1)]  <= 1'b1;
            bit_idx <= bit_idx - IDX_WIDTH'(1);
`ifdef SAR_SETTLE_EN
            state      <= S_SETTLE;
            dec_enable <= 1'b0;
`endif
          end else begin
            result     <= {trial[RESOLUTION-1:1], comp};
            trial      <= '0;
            busy       <= 1'b0;
            dec_enable <= 1'b0;
            done       <= 1'b1;
            state      <= S_DONE;
          end
        end
        S_DONE: begin
          done  <= 1'b0;
          state <= S_IDLE;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_sar_controller.sv
// tb_sar_controller: directed bench with a schedule-level model.
// Also covers the SAR_SETTLE_EN build.
module tb_sar_controller;
  import sar_pkg::*;

  localparam int RES = 8;
  localparam int SC  = 2;
`ifdef SAR_SETTLE_EN
  localparam int CONV = 2 * RES;
`else
  localparam int CONV = RES;
`endif
  localparam int DONE_AGE = SC + CONV;
  localparam int LAT      = SC + CONV + 1;
  localparam int SPACING  = SC + CONV + 2;

  logic           clk = 1'b0;
  logic           reset, start, comp;
  logic           busy, sample, dec_enable, done;
  logic [2:0]     bit_idx;
  logic [RES-1:0] trial, result;
  logic [RES-1:0] model_v;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int acc_cyc = 0;
  int done_q[$];

  always #5 clk = ~clk;

  // Comparator: analog input modelled as the value model_v.
  assign comp = (model_v >= trial);

  sar_controller #(
    .RESOLUTION(RES), .IDX_WIDTH(3), .SAMPLE_CYCLES(SC)
  ) dut (
    .clk(clk), .reset(reset), .start(start), .comp(comp),
    .busy(busy), .sample(sample), .dec_enable(dec_enable),
    .bit_idx(bit_idx), .trial(trial), .result(result),
    .done(done)
  );

  function automatic logic [RES-1:0] search(input logic [RES-1:0] v);
    logic [RES-1:0] code = '0;
    logic [RES-1:0] t;
    for (int b = RES - 1; b >= 0; b--) begin
      t = code | (RES'(1) << b);
      if (v >= t) code = t;
    end
    return code;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model + per-cycle compare.
  initial begin : model
    int age = -1;
    bit armed = 0;
    logic s, r;
    logic [RES-1:0] cv = '0;
    logic [RES-1:0] er = '0;
    logic [RES-1:0] code, hi;
    logic e_busy, e_smp, e_de, e_done;
    logic [2:0] e_idx;
    logic [RES-1:0] e_trial;
    int k, j, b;
    forever begin
      @(posedge clk);
      s = start;
      r = reset;
      #1;
      cyc++;
      if (r) begin
        age = -1;
        er  = '0;
      end else if (age < 0) begin
        if (s) begin
          age = 0;
          cv = model_v;
          acc_cyc = cyc;
        end
      end else begin
        age++;
        if (age == DONE_AGE + 1) age = -1;
      end
      if (age == DONE_AGE) er = search(cv);
      e_busy = 0; e_smp = 0; e_de = 0; e_done = 0;
      e_idx = '0; e_trial = '0;
      if (age >= 0 && age < SC) begin
        e_busy = 1; e_smp = 1;
      end else if (age >= SC && age < DONE_AGE) begin
        e_busy = 1;
        k = age - SC;
`ifdef SAR_SETTLE_EN
        j = k / 2;
        e_de = (k % 2) == 1;
`else
        j = k;
        e_de = 1;
`endif
        b = RES - 1 - j;
        e_idx = 3'(b);
        code = search(cv);
        hi = ~((RES'(1) << (b + 1)) - RES'(1));
        if (b == RES - 1) hi = '0;
        e_trial = (code & hi) | (RES'(1) << b);
      end else if (age == DONE_AGE) begin
        e_done = 1;
      end
      if (done === 1'b1) done_q.push_back(cyc);
      if (r) armed = 1;
      if (armed) begin
        checks++;
        if ({busy, sample, dec_enable, done, bit_idx, trial, result}
            !== {e_busy, e_smp, e_de, e_done, e_idx, e_trial, er}) begin
          errors++;
          $display(
            "FAIL cycle %0d: got b%b s%b d%b dn%b i%0d t%h r%h want b%b s%b d%b dn%b i%0d t%h r%h",
            cyc, busy, sample, dec_enable, done, bit_idx, trial, result,
            e_busy, e_smp, e_de, e_done, e_idx, e_trial, er);
        end
      end
    end
  end

  task automatic wait_done(input int maxc, output bit ok);
    ok = 0;
    for (int i = 0; i < maxc && !ok; i++) begin
      @(negedge clk);
      if (done === 1'b1) ok = 1;
    end
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic convert(input logic [RES-1:0] v, input string nm);
    bit ok;
    model_v = v;
    pulse_start();
    wait_done(60, ok);
    chk({nm, " timeout"}, int'(ok), 1);
    chk({nm, " result"}, int'(result), int'(v));
    repeat (3) @(negedge clk);
  endtask

  initial begin : stim
    bit ok;
    int n, base;
    reset = 1'b1;
    start = 1'b0;
    model_v = '0;
    repeat (3) @(negedge clk);
    chk("rst busy", int'(busy), 0);
    chk("rst trial", int'(trial), 0);
    chk("rst result", int'(result), 0);
    chk("rst done", int'(done), 0);
    reset = 1'b0;
    @(negedge clk);

    model_v = 8'hA5;
    pulse_start();
    wait_done(60, ok);
    chk("a5 timeout", int'(ok), 1);
    chk("a5 result", int'(result), 'hA5);
    if (ok) chk("a5 latency", done_q[$] - acc_cyc + 1, LAT);
    chk("model a5", int'(search(8'hA5)), 'hA5);
    chk("model 3c", int'(search(8'h3C)), 'h3C);
    repeat (3) @(negedge clk);

    convert(8'h00, "v00");
    convert(8'hFF, "vff");

    base = done_q.size();
    model_v = 8'h5A;
    pulse_start();
    ok = 0;
    for (int i = 0; i < 40 && !ok; i++) begin
      @(negedge clk);
      if (dec_enable === 1'b1) ok = 1;
    end
    chk("ign reach conv", int'(ok), 1);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_done(60, ok);
    chk("ign timeout", int'(ok), 1);
    chk("ign result", int'(result), 'h5A);
    repeat (30) @(negedge clk);
    chk("ign one done", done_q.size() - base, 1);
    chk("ign result kept", int'(result), 'h5A);

    model_v = 8'hA5;
    pulse_start();
    n = 0;
    for (int i = 0; i < 60 && n < 4; i++) begin
      @(negedge clk);
      if (dec_enable === 1'b1) n++;
    end
    chk("rst reach 4th", n, 4);
    base = done_q.size();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("abort out",
        int'({busy, sample, dec_enable, done, bit_idx}), 0);
    chk("abort trial", int'(trial), 0);
    chk("abort result", int'(result), 0);
    chk("abort idle", int'(dut.state == S_IDLE), 1);
    repeat (40) @(negedge clk);
    chk("abort no done", done_q.size() - base, 0);

    model_v = 8'h3C;
    base = done_q.size();
    @(negedge clk);
    start = 1'b1;
    for (int c = 0; c < 3; c++) begin
      wait_done(60, ok);
      chk("b2b timeout", int'(ok), 1);
      chk("b2b result", int'(result), 'h3C);
    end
    start = 1'b0;
    repeat (30) @(negedge clk);
    chk("b2b count", done_q.size() - base, 3);
    if (done_q.size() - base == 3) begin
      chk("b2b gap1", done_q[base + 1] - done_q[base], SPACING);
      chk("b2b gap2", done_q[base + 2] - done_q[base + 1], SPACING);
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/sar_controller.md
SAR_CONTROLLER -- requirements
Module: sar_controller

Interface
REQ-001 Parameter RESOLUTION, default 8: number of result bits; it also sets the width of the downstream one-hot bit decoder (2**IDX_WIDTH >= RESOLUTION).
REQ-002 Parameter IDX_WIDTH, default 3: bit-index width; IDX_WIDTH = clog2(RESOLUTION).
REQ-003 Parameter SAMPLE_CYCLES, default 2, range 1..15: length of the sampling phase in cycles.
REQ-004 clk  input  1  single clock; all state changes on the rising edge.
REQ-005 reset  input  1  synchronous reset, active-high.
REQ-006 start  input  1  conversion request; sampled only in IDLE.
REQ-007 comp  input  1  comparator output; 1 = analog input >= current trial code.
REQ-008 busy  output  1  high in SAMPLE, CONVERT (and SETTLE, when compiled in).
REQ-009 sample  output  1  track/hold control; high only in SAMPLE.
REQ-010 dec_enable  output  1  enable for the downstream bit decoder; high only in CONVERT.
REQ-011 bit_idx  output  IDX_WIDTH  bit under trial; feeds the decoder input.
REQ-012 trial  output  RESOLUTION  DAC trial code.
REQ-013 result  output  RESOLUTION  last completed conversion; held until the next DONE.
REQ-014 done  output  1  one-cycle pulse when result updates.

Function
REQ-015 The FSM states shall be IDLE, SAMPLE, CONVERT and DONE, plus SETTLE when SAR_SETTLE_EN is defined.
REQ-016 In IDLE, start=1 shall move the FSM to SAMPLE on the next edge, loading a sample counter with SAMPLE_CYCLES-1.
REQ-017 SAMPLE shall last exactly SAMPLE_CYCLES cycles, then enter CONVERT with bit_idx=RESOLUTION-1 and trial = 1 << (RESOLUTION-1).
REQ-018 Each CONVERT cycle shall evaluate comp against bit bit_idx of trial:
  - comp=1: keep the bit.
  - comp=0: clear the bit.
  - If bit_idx>0, set bit bit_idx-1 and decrement bit_idx.
REQ-019 The CONVERT cycle with bit_idx=0 shall resolve the LSB, copy the final code to result and enter DONE.
REQ-020 DONE shall last one cycle with done=1, then return to IDLE.
REQ-021 Without SAR_SETTLE_EN, latency from the start-accept edge to the done pulse shall be SAMPLE_CYCLES+RESOLUTION+1 cycles.
REQ-022 start asserted while busy=1 or in DONE shall be ignored; there is no queuing.
REQ-023 start held high continuously shall produce back-to-back conversions, each beginning on the cycle after DONE.
REQ-024 bit_idx shall never wrap below 0; it shall be 0 in IDLE, SAMPLE and DONE.
REQ-025 trial shall be 0 outside SAMPLE/CONVERT/SETTLE, and result shall be unchanged except on entry to DONE.

Reset
REQ-026 reset=1 shall force state IDLE and drive busy=0, sample=0, dec_enable=0, done=0, bit_idx=0, trial=0 and result=0 on the next edge.
REQ-027 reset asserted mid-conversion shall abort the conversion without a done pulse; result shall be cleared to 0.
REQ-028 reset shall take priority over start.

Configuration
REQ-029 Macro SAR_SETTLE_EN:
  - Defined: one SETTLE cycle (dec_enable=0, comp ignored) precedes every CONVERT cycle, so latency is SAMPLE_CYCLES+2*RESOLUTION+1.
  - Undefined: no SETTLE state exists and the REQ-021 latency applies.

Structure
REQ-030 Package sar_pkg shall hold the state enum type and a default-resolution localparam shared with the decoder bench.
REQ-031 sar_controller shall be a single module with no sub-module; the one-hot decoder is instantiated alongside it at data-path level, not inside it.

Verification
REQ-032 RESOLUTION=8, SAMPLE_CYCLES=2, comp modelled as (0xA5 >= trial), start pulse -> result=0xA5 with done exactly 11 cycles after start is accepted.
REQ-033 Model values 0x00 and 0xFF -> result=0x00 and 0xFF respectively; bit_idx steps 7..0 with no wrap.
REQ-034 start pulsed during CONVERT -> ignored; one done pulse only, and result is unchanged by the extra start.
REQ-035 reset asserted at the 4th CONVERT cycle -> next cycle all outputs are 0, state is IDLE, and no done pulse occurs.
REQ-036 start held high for three conversions of 0x3C -> three done pulses spaced 12 cycles apart, result=0x3C each time.
REQ-037 SAR_SETTLE_EN defined, model 0xA5 -> result=0xA5, latency 19 cycles, and dec_enable alternates 0/1 through the conversion.
